// File: rtl/bias_buffer_if.sv
// bias_buffer_if: load-burst, write-stream and bias-read signals of the bias buffer.
interface bias_buffer_if #(parameter int DATA_W = 32, parameter int ADDR_W = 8);
  logic              load_start;
  logic [ADDR_W-1:0] load_addr;
  logic [ADDR_W-1:0] load_len;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              load_busy;
  logic              load_done;
  logic              rd_en;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] bias_data;
  logic              bias_valid;
  modport master (
    output load_start, load_addr, load_len, wr_valid, wr_data, rd_en, b_addr,
    input  wr_ready, load_busy, load_done, bias_data, bias_valid
  );
  modport slave (
    input  load_start, load_addr, load_len, wr_valid, wr_data, rd_en, b_addr,
    output wr_ready, load_busy, load_done, bias_data, bias_valid
  );
endinterface

// File: rtl/bias_buffer.sv
// bias_buffer: burst-loaded bias memory with a latency-1 read port.
// Define BIAS_RD_PIPE_EN to add an output register (read latency 2).
module bias_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  bias_buffer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic              hs;
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  assign bus.wr_ready  = state_q == LOAD;
  assign bus.load_busy = state_q != IDLE;
  assign bus.load_done = state_q == DONE;
  assign hs = bus.wr_valid && state_q == LOAD;
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    remaining_d = remaining_q;
    if (state_q == IDLE && bus.load_start && bus.load_len != '0) begin
      state_d     = LOAD;
      wr_ptr_d    = bus.load_addr;
      remaining_d = bus.load_len;
    end
    if (hs) begin
      wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
      remaining_d = remaining_q - ADDR_W'(1);
      state_d     = remaining_q == ADDR_W'(1) ? DONE : LOAD;
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      remaining_q <= remaining_d;
    end
  end
  // Storage is deliberately not reset so an aborted burst keeps its words.
  always_ff @(posedge clk) begin
    if (hs) mem_q[wr_ptr_q] <= bus.wr_data;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= mem_q[bus.b_addr];
    end
  end
`ifdef BIAS_RD_PIPE_EN
  logic              pipe_valid_q;
  logic [DATA_W-1:0] pipe_data_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_valid_q <= 1'b0;
      pipe_data_q  <= '0;
    end else begin
      pipe_valid_q <= rd_valid_q;
      if (rd_valid_q) pipe_data_q <= rd_data_q;
    end
  end
  assign bus.bias_valid = pipe_valid_q;
  assign bus.bias_data  = pipe_data_q;
`else
  assign bus.bias_valid = rd_valid_q;
  assign bus.bias_data  = rd_data_q;
`endif
endmodule

// File: tb/tb_bias_buffer.sv
// tb_bias_buffer: table-driven check of bias_buffer loads and reads, plus an async-reset sequence.
module tb_bias_buffer;
`ifdef BIAS_RD_PIPE_EN
  localparam int LX = 1;
`else
  localparam int LX = 0;
`endif
  localparam int N = 24;
  typedef struct {
    logic        ls;
    logic [7:0]  la;
    logic [7:0]  ll;
    logic        wv;
    logic [31:0] wd;
    logic        re;
    logic [7:0]  ra;
    logic        e_rdy;
    logic        e_busy;
    logic        e_done;
    logic [31:0] e_bd;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  vec_t vec [N+1];
  bias_buffer_if #(.DATA_W(32), .ADDR_W(8)) bus ();
  bias_buffer #(.DATA_W(32), .ADDR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic vec_t v(logic ls, logic [7:0] la, logic [7:0] ll, logic wv, logic [31:0] wd,
                             logic re, logic [7:0] ra, logic rdy, logic busy, logic done, logic [31:0] bd);
    vec_t r;
    r.ls = ls; r.la = la; r.ll = ll; r.wv = wv; r.wd = wd; r.re = re; r.ra = ra;
    r.e_rdy = rdy; r.e_busy = busy; r.e_done = done; r.e_bd = bd;
    return r;
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic drive(vec_t r);
    bus.load_start = r.ls; bus.load_addr = r.la; bus.load_len = r.ll;
    bus.wr_valid = r.wv; bus.wr_data = r.wd; bus.rd_en = r.re; bus.b_addr = r.ra;
  endtask
  initial begin
    vec[0]  = v(1,   0, 3, 0, 0,    0,   0, 1, 1, 0, 0);
    vec[1]  = v(0,   0, 0, 1, 'h11, 0,   0, 1, 1, 0, 0);
    vec[2]  = v(0,   0, 0, 1, 'h22, 0,   0, 1, 1, 0, 0);
    vec[3]  = v(0,   0, 0, 1, 'h33, 0,   0, 0, 1, 1, 0);
    vec[4]  = v(0,   0, 0, 0, 0,    1,   0, 0, 0, 0, 'h11);
    vec[5]  = v(0,   0, 0, 0, 0,    1,   1, 0, 0, 0, 'h22);
    vec[6]  = v(1, 254, 3, 0, 0,    1,   2, 1, 1, 0, 'h33);
    vec[7]  = v(0,   0, 0, 1, 'h44, 0,   0, 1, 1, 0, 0);
    vec[8]  = v(1,  10, 5, 1, 'h55, 0,   0, 1, 1, 0, 0);
    vec[9]  = v(0,   0, 0, 1, 'h66, 0,   0, 0, 1, 1, 0);
    vec[10] = v(0,   0, 0, 0, 0,    1, 254, 0, 0, 0, 'h44);
    vec[11] = v(0,   0, 0, 0, 0,    1, 255, 0, 0, 0, 'h55);
    vec[12] = v(1,   0, 0, 0, 0,    1,   0, 0, 0, 0, 'h66);
    vec[13] = v(0,   0, 0, 0, 0,    0,   0, 0, 0, 0, 0);
    vec[14] = v(1,   5, 2, 0, 0,    0,   0, 1, 1, 0, 0);
    vec[15] = v(0,   0, 0, 1, 'hAA, 0,   0, 1, 1, 0, 0);
    vec[16] = v(0,   0, 0, 0, 'hCC, 0,   0, 1, 1, 0, 0);
    vec[17] = v(0,   0, 0, 1, 'h77, 0,   0, 0, 1, 1, 0);
    vec[18] = v(0,   0, 0, 1, 'hEE, 0,   0, 0, 0, 0, 0);
    vec[19] = v(1,   5, 1, 1, 'hEE, 0,   0, 1, 1, 0, 0);
    vec[20] = v(0,   0, 0, 1, 'hBB, 1,   5, 0, 1, 1, 'hAA);
    vec[21] = v(0,   0, 0, 0, 0,    1,   5, 0, 0, 0, 'hBB);
    vec[22] = v(0,   0, 0, 0, 0,    1,   6, 0, 0, 0, 'h77);
    vec[23] = v(0,   0, 0, 0, 0,    0,   0, 0, 0, 0, 0);
    vec[N]  = v(0,   0, 0, 0, 0,    0,   0, 0, 0, 0, 0);
    drive(vec[N]);
    @(negedge clk);
    @(negedge clk);
    chk("reset wr_ready", 32'(bus.wr_ready), 0);
    chk("reset load_busy", 32'(bus.load_busy), 0);
    chk("reset load_done", 32'(bus.load_done), 0);
    chk("reset bias_valid", 32'(bus.bias_valid), 0);
    chk("reset bias_data", bus.bias_data, 0);
    rst = 1'b1;
    for (int i = 0; i <= N; i++) begin
      drive(vec[i]);
      @(negedge clk);
      chk($sformatf("v%0d wr_ready", i), 32'(bus.wr_ready), 32'(vec[i].e_rdy));
      chk($sformatf("v%0d load_busy", i), 32'(bus.load_busy), 32'(vec[i].e_busy));
      chk($sformatf("v%0d load_done", i), 32'(bus.load_done), 32'(vec[i].e_done));
      if (i - LX >= 0) begin
        chk($sformatf("v%0d bias_valid", i), 32'(bus.bias_valid), 32'(vec[i-LX].re));
        if (vec[i-LX].re) chk($sformatf("v%0d bias_data", i), bus.bias_data, vec[i-LX].e_bd);
      end else begin
        chk($sformatf("v%0d bias_valid", i), 32'(bus.bias_valid), 0);
      end
    end
    // Abort a 3-word burst after one word with an asynchronous reset.
    bus.load_start = 1; bus.load_addr = 0; bus.load_len = 3;
    @(negedge clk);
    bus.load_start = 0;
    chk("abort busy", 32'(bus.load_busy), 1);
    bus.wr_valid = 1; bus.wr_data = 'h99; bus.rd_en = 1; bus.b_addr = 6;
    @(negedge clk);
    bus.wr_valid = 0; bus.rd_en = 0;
    if (LX != 0) @(negedge clk);
    chk("abort pre ready", 32'(bus.wr_ready), 1);
    chk("abort pre bias_valid", 32'(bus.bias_valid), 1);
    chk("abort pre bias_data", bus.bias_data, 'h77);
    #2 rst = 1'b0;
    #1;
    chk("async wr_ready", 32'(bus.wr_ready), 0);
    chk("async load_busy", 32'(bus.load_busy), 0);
    chk("async load_done", 32'(bus.load_done), 0);
    chk("async bias_valid", 32'(bus.bias_valid), 0);
    chk("async bias_data", bus.bias_data, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post reset done %0d", k), 32'(bus.load_done), 0);
      chk($sformatf("post reset busy %0d", k), 32'(bus.load_busy), 0);
    end
    bus.rd_en = 1; bus.b_addr = 0;
    @(negedge clk);
    bus.rd_en = 0;
    if (LX != 0) @(negedge clk);
    chk("kept word valid", 32'(bus.bias_valid), 1);
    chk("kept word data", bus.bias_data, 'h99);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bias_buffer.md
BIAS_BUFFER -- requirements
Module: bias_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, bias word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 8, address width; depth = 2^ADDR_W words.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port load_start, input, 1, one-cycle pulse that starts a bias load burst.
REQ-006 The block SHALL have port load_addr, input, ADDR_W, first word address of the burst, sampled with load_start.
REQ-007 The block SHALL have port load_len, input, ADDR_W, word count of the burst, sampled with load_start.
REQ-008 The block SHALL have port wr_valid, input, 1, wr_data holds a valid word.
REQ-009 The block SHALL have port wr_data, input, DATA_W, incoming bias word.
REQ-010 The block SHALL have port wr_ready, output, 1, the buffer accepts a word this cycle.
REQ-011 The block SHALL have port load_busy, output, 1, a burst is in progress.
REQ-012 The block SHALL have port load_done, output, 1, one-cycle pulse after the last word of a burst is written.
REQ-013 The block SHALL have port rd_en, input, 1, read strobe from the bias address generator.
REQ-014 The block SHALL have port b_addr, input, ADDR_W, read address from the bias address generator.
REQ-015 The block SHALL have port bias_data, output, DATA_W, read data.
REQ-016 The block SHALL have port bias_valid, output, 1, bias_data is valid this cycle.

Function
REQ-017 The load FSM SHALL have states IDLE, LOAD and DONE.
REQ-018 IDLE->LOAD SHALL occur on load_start with load_len!=0; the FSM latches load_addr into wr_ptr and load_len into remaining.
REQ-019 load_start with load_len==0 SHALL be ignored, with no load_done.
REQ-020 In LOAD, wr_ready SHALL be 1; otherwise it SHALL be 0.
REQ-021 A handshake SHALL occur when wr_valid and wr_ready are both 1: mem[wr_ptr]<=wr_data, wr_ptr increments modulo 2^ADDR_W (wrap 255->0), and remaining decrements.
REQ-022 The handshake that writes the word with remaining==1 SHALL move the FSM LOAD->DONE.
REQ-023 DONE SHALL last one cycle, assert load_done, then return to IDLE.
REQ-024 load_busy SHALL be 1 in LOAD and DONE.
REQ-025 load_start SHALL be ignored in LOAD and DONE.
REQ-026 wr_valid without wr_ready SHALL have no effect.
REQ-027 Reads SHALL be independent of the load FSM; a read issued in any state is serviced.
REQ-028 rd_en at cycle N SHALL give bias_data=mem[b_addr] and bias_valid=1 at cycle N+1 (default latency 1).
REQ-029 bias_valid SHALL be 0 in every cycle not following a read; bias_data SHALL hold its last value when no read occurs.
REQ-030 Back-to-back rd_en SHALL sustain one result per cycle.
REQ-031 When a read and a write hit the same address in the same cycle, the read SHALL return the old word (read-before-write).

Reset
REQ-032 rst low SHALL immediately force FSM=IDLE, wr_ptr=0, remaining=0, wr_ready=0, load_busy=0, load_done=0, bias_valid=0 and bias_data=0.
REQ-033 Memory contents SHALL NOT be reset; a reset during LOAD abandons the burst with no load_done, and words already written remain.

Configuration
REQ-034 With macro BIAS_RD_PIPE_EN defined, an extra output register SHALL be added: read latency 2 cycles, bias_valid and bias_data delayed together, throughput still one read per cycle, and both registers reset to 0.
REQ-035 Without BIAS_RD_PIPE_EN, read latency SHALL be 1 cycle, as in REQ-028.

Verification
REQ-036 load_start, load_addr=0, load_len=3, words 0x11/0x22/0x33 on consecutive cycles -> load_done one cycle after the third handshake; reads of addresses 0,1,2 return 0x11, 0x22, 0x33 at latency 1 (latency 2 with BIAS_RD_PIPE_EN).
REQ-037 load_addr=254, load_len=3 -> words land at 254, 255 and 0 (wrap).
REQ-038 wr_valid toggled 1,0,1,0 during a 2-word load -> exactly 2 writes, load_done after the second.
REQ-039 load_start with load_len=0 -> load_busy stays 0 and no load_done; a second load_start during LOAD does not disturb the first burst.
REQ-040 rd_en and a write to address 5 (old 0xAA, new 0xBB) in the same cycle -> read returns 0xAA; a later read returns 0xBB.
REQ-041 rst asserted mid-LOAD after 1 of 3 words -> outputs go to 0 asynchronously, no load_done, and address 0 holds the written word.
